cpu_sequencer: RTL and testbench
================================

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter MEM_LAT, default 1, meaning extra memory read wait cycles, legal range 0..15.
REQ-002 Parameter CNT_W, default 4, meaning wait-counter width; it SHALL satisfy 2^CNT_W > MEM_LAT.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 s  input  1  start request, sampled only in WAIT.
REQ-006 opcode  input  3  instruction opcode field.
REQ-007 op  input  2  instruction op/ALU field.
REQ-008 w  output  1  idle indicator, high only in WAIT.
REQ-009 nsel  output  3  one-hot register-field select: 100=Rn, 010=Rd, 001=Rm, 000=none.
REQ-010 vsel  output  4  one-hot writeback source: 1000=mdata, 0100=sximm8, 0010=PC, 0001=C.
REQ-011 write, loada, loadb, asel, bsel, loadc, loads, load_addr  output  1 each  datapath strobes.
REQ-012 mem_cmd  output  2  memory command: 00=none, 01=read, 10=write.
REQ-013 err  output  1  one-cycle pulse on an illegal instruction.
REQ-014 halted  output  1  high while in HALT.

Function
REQ-015 Outputs SHALL be a Moore function of state only; every output not listed for a state SHALL be 0, with no X values driven.
REQ-016 States: WAIT, DECODE, MOVIM, MOVR_B, MOVR_C, GETA, GETB, ALU, WRC, LD_A, LD_ADD, LD_ADDR, MEMRD, WRM, ST_B, ST_C, MEMWR, HALT.
REQ-017 WAIT: w=1; if s=1 go to DECODE, else stay in WAIT.
REQ-018 DECODE routing:
- 110/10 -> MOVIM
- 110/00 -> MOVR_B
- 101/11 (MVN) -> GETB
- 101/other -> GETA
- 011/00 (LDR) or 100/00 (STR) -> LD_A
- 111 -> HALT
- anything else -> WAIT, with err=1 during the DECODE cycle.
REQ-019 MOVIM: nsel=100, vsel=0100, write=1; next state WAIT.
REQ-020 MOVR_B: nsel=001, loadb=1 -> MOVR_C: asel=1, bsel=0, loadc=1 -> WRC.
REQ-021 GETA: nsel=100, loada=1 -> GETB: nsel=001, loadb=1 -> ALU.
REQ-022 ALU: asel=0 except asel=1 for MVN; bsel=0; CMP (op=01) asserts loads=1 and goes to WAIT; all other ops assert loadc=1 and go to WRC.
REQ-023 WRC: nsel=010, vsel=0001, write=1; next state WAIT.
REQ-024 LD_A: nsel=100, loada=1 -> LD_ADD: asel=0, bsel=1, loadc=1 -> LD_ADDR: load_addr=1.
REQ-025 From LD_ADDR, LDR goes to MEMRD and STR goes to ST_B; opcode SHALL be held stable by the datapath for the whole instruction.
REQ-026 MEMRD: mem_cmd=01; the counter is loaded with MEM_LAT on entry and decrements each cycle; the state exits to WRM in the cycle the counter reads 0, so MEMRD lasts MEM_LAT+1 cycles.
REQ-027 WRM: mem_cmd=01 (held), nsel=010, vsel=1000, write=1; next state WAIT.
REQ-028 ST_B: nsel=010, loadb=1 -> ST_C: asel=1, bsel=0, loadc=1 -> MEMWR: mem_cmd=10, one cycle -> WAIT.
REQ-029 HALT: halted=1, w=0; only reset leaves this state, and s is ignored.
REQ-030 With MEM_LAT=0, MEMRD SHALL last exactly 1 cycle and the counter SHALL never underflow.
REQ-031 Cycle counts from the WAIT cycle with s=1 back to re-entering WAIT:
- MOVIM: 3
- MOV reg: 5
- CMP: 5
- ADD, AND: 6
- MVN: 5
- STR: 8
- LDR: 7+MEM_LAT
REQ-032 If s is still high on return to WAIT, a new instruction SHALL start, with DECODE on the next edge.

Reset
REQ-033 Asserting reset SHALL force WAIT and zero the counter immediately and asynchronously, including mid-instruction and in HALT.
REQ-034 During and directly after reset, outputs SHALL be w=1, err=0, halted=0, mem_cmd=00, and all other outputs 0.
REQ-035 Reset deassertion SHALL take effect at the next rising edge, and s SHALL be sampled on that edge.

Verification
REQ-036 Reset, then s=1 with opcode=110, op=10 -> DECODE, then MOVIM with nsel=100, vsel=0100, write=1, then w=1 on cycle 3.
REQ-037 ADD (101/00) -> loada with nsel=100, loadb with nsel=001, loadc=1, then write=1 with nsel=010 and vsel=0001; w returns after 6 cycles; CMP gives loads=1 and never write.
REQ-038 LDR with MEM_LAT=3 -> mem_cmd=01 for exactly 5 cycles (4 MEMRD + WRM); write=1 with vsel=1000 only in the final cycle; total 10 cycles.
REQ-039 STR -> load_addr pulse, then loadb with nsel=010, then a single mem_cmd=10 cycle; write never asserted.
REQ-040 opcode=010 -> err=1 for exactly one cycle and return to WAIT; opcode=111 -> halted=1 held for 20 cycles with s toggling; reset then gives w=1.
REQ-041 Reset asserted mid-MEMRD (between edges) -> mem_cmd=00 and w=1 immediately; after release, next s=1 starts cleanly.

Source files
------------

// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
//
// Control FSM for a small multi-cycle CPU datapath. It sits idle in WAIT until
// a start request arrives. It then decodes the instruction fields and steps
// through the datapath strobes for one instruction: move immediate, move
// register, the ALU ops (ADD, CMP, AND, MVN), load, store and halt. After the
// instruction it returns to WAIT.
//
// Parameters
//   MEM_LAT  extra memory read wait cycles (0..15)
//   CNT_W    wait-counter width, must satisfy 2**CNT_W > MEM_LAT
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset (forces WAIT)
//   s          start request, sampled only in WAIT
//   opcode     instruction opcode field, held stable for the whole instruction
//   op         instruction op / ALU field
//   w          idle indicator, high only in WAIT
//   nsel       register-field select, one-hot: 100=Rn 010=Rd 001=Rm
//   vsel       writeback source, one-hot: 1000=mdata 0100=sximm8 0010=PC 0001=C
//   write      register file write enable
//   loada      load A register
//   loadb      load B register
//   asel       A-side mux select (1 = zero operand)
//   bsel       B-side mux select (1 = sximm5)
//   loadc      load C register
//   loads      load status flags
//   load_addr  load data address register
//   mem_cmd    memory command: 00=none 01=read 10=write
//   err        one-cycle pulse while decoding an illegal instruction
//   halted     high while in HALT
// -----------------------------------------------------------------------------
module cpu_sequencer #(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       w,
  output logic [2:0] nsel,
  output logic [3:0] vsel,
  output logic       write,
  output logic       loada,
  output logic       loadb,
  output logic       asel,
  output logic       bsel,
  output logic       loadc,
  output logic       loads,
  output logic       load_addr,
  output logic [1:0] mem_cmd,
  output logic       err,
  output logic       halted
);

  typedef enum logic [4:0] {
    S_WAIT    = 5'd0,
    S_DECODE  = 5'd1,
    S_MOVIM   = 5'd2,
    S_MOVR_B  = 5'd3,
    S_MOVR_C  = 5'd4,
    S_GETA    = 5'd5,
    S_GETB    = 5'd6,
    S_ALU     = 5'd7,
    S_WRC     = 5'd8,
    S_LD_A    = 5'd9,
    S_LD_ADD  = 5'd10,
    S_LD_ADDR = 5'd11,
    S_MEMRD   = 5'd12,
    S_WRM     = 5'd13,
    S_ST_B    = 5'd14,
    S_ST_C    = 5'd15,
    S_MEMWR   = 5'd16,
    S_HALT    = 5'd17
  } state_t;

  localparam logic [2:0] NSEL_RN = 3'b100;
  localparam logic [2:0] NSEL_RD = 3'b010;
  localparam logic [2:0] NSEL_RM = 3'b001;

  localparam logic [3:0] VSEL_MDATA  = 4'b1000;
  localparam logic [3:0] VSEL_SXIMM8 = 4'b0100;
  localparam logic [3:0] VSEL_C      = 4'b0001;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] OP_CMP = 2'b01;
  localparam logic [1:0] OP_MVN = 2'b11;

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;

  // The current state and the read wait counter both live in this register.
  // NOTE: sequential state is updated with non-blocking assignments, so every
  // flop samples values from before the edge no matter how the code is ordered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_WAIT;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (state != S_MEMRD && state_n == S_MEMRD) begin
        cnt <= LAT_LOAD;
      end else if (state == S_MEMRD && cnt != '0) begin
        // Saturate at zero so MEM_LAT=0 never wraps the counter.
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Next-state logic and outputs. Outputs depend on the state only. The one
  // exception is err, which flags an illegal opcode/op while in DECODE.
  // NOTE: every output and state_n gets a default before the case statement.
  // Without these defaults, any path that does not assign a signal would
  // infer a latch.
  always_comb begin
    state_n   = state;
    w         = 1'b0;
    nsel      = 3'b000;
    vsel      = 4'b0000;
    write     = 1'b0;
    loada     = 1'b0;
    loadb     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    load_addr = 1'b0;
    mem_cmd   = MEM_NONE;
    err       = 1'b0;
    halted    = 1'b0;

    unique case (state)
      S_WAIT: begin
        w = 1'b1;
        if (s) state_n = S_DECODE;
      end

      S_DECODE: begin
        unique case (opcode)
          OPC_MOV: begin
            if (op == 2'b10) begin
              state_n = S_MOVIM;
            end else if (op == 2'b00) begin
              state_n = S_MOVR_B;
            end else begin
              state_n = S_WAIT;
              err     = 1'b1;
            end
          end
          OPC_ALU: state_n = (op == OP_MVN) ? S_GETB : S_GETA;
          OPC_LDR, OPC_STR: begin
            if (op == 2'b00) begin
              state_n = S_LD_A;
            end else begin
              state_n = S_WAIT;
              err     = 1'b1;
            end
          end
          OPC_HALT: state_n = S_HALT;
          default: begin
            state_n = S_WAIT;
            err     = 1'b1;
          end
        endcase
      end

      S_MOVIM: begin
        nsel    = NSEL_RN;
        vsel    = VSEL_SXIMM8;
        write   = 1'b1;
        state_n = S_WAIT;
      end

      // Register move: route Rm through B with a zero A operand, then write C.
      S_MOVR_B: begin
        nsel    = NSEL_RM;
        loadb   = 1'b1;
        state_n = S_MOVR_C;
      end

      S_MOVR_C: begin
        asel    = 1'b1;
        loadc   = 1'b1;
        state_n = S_WRC;
      end

      S_GETA: begin
        nsel    = NSEL_RN;
        loada   = 1'b1;
        state_n = S_GETB;
      end

      S_GETB: begin
        nsel    = NSEL_RM;
        loadb   = 1'b1;
        state_n = S_ALU;
      end

      // MVN skips GETA, so A is forced to zero here. CMP only updates the
      // status flags and never writes a result back.
      S_ALU: begin
        asel = (op == OP_MVN);
        if (op == OP_CMP) begin
          loads   = 1'b1;
          state_n = S_WAIT;
        end else begin
          loadc   = 1'b1;
          state_n = S_WRC;
        end
      end

      S_WRC: begin
        nsel    = NSEL_RD;
        vsel    = VSEL_C;
        write   = 1'b1;
        state_n = S_WAIT;
      end

      // Load and store both compute the address Rn + sximm5 and latch it.
      S_LD_A: begin
        nsel    = NSEL_RN;
        loada   = 1'b1;
        state_n = S_LD_ADD;
      end

      S_LD_ADD: begin
        bsel    = 1'b1;
        loadc   = 1'b1;
        state_n = S_LD_ADDR;
      end

      S_LD_ADDR: begin
        load_addr = 1'b1;
        state_n   = (opcode == OPC_LDR) ? S_MEMRD : S_ST_B;
      end

      S_MEMRD: begin
        mem_cmd = MEM_READ;
        if (cnt == '0) state_n = S_WRM;
      end

      // The read command stays asserted so mdata stays valid during the write.
      S_WRM: begin
        mem_cmd = MEM_READ;
        nsel    = NSEL_RD;
        vsel    = VSEL_MDATA;
        write   = 1'b1;
        state_n = S_WAIT;
      end

      // Store: pass Rd through the ALU unchanged to form the write data.
      S_ST_B: begin
        nsel    = NSEL_RD;
        loadb   = 1'b1;
        state_n = S_ST_C;
      end

      S_ST_C: begin
        asel    = 1'b1;
        loadc   = 1'b1;
        state_n = S_MEMWR;
      end

      S_MEMWR: begin
        mem_cmd = MEM_WRITE;
        state_n = S_WAIT;
      end

      S_HALT: begin
        halted  = 1'b1;
        state_n = S_HALT;
      end

      default: state_n = S_WAIT;
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cpu_sequencer
//
// Directed testbench for cpu_sequencer. Two instances share the same inputs:
// dut_a uses MEM_LAT=3 and dut_b uses MEM_LAT=0. They stay in lock-step except
// during the memory read wait, so most checks look at dut_a, and the load
// sequence checks both instances.
// Every output is packed into one 20-bit word:
//   {w, nsel[2:0], vsel[3:0], write, loada, loadb, asel, bsel, loadc, loads,
//    load_addr, mem_cmd[1:0], err, halted}
// -----------------------------------------------------------------------------
module tb_cpu_sequencer;

  localparam logic [7:0] WR = 8'h80;  // write
  localparam logic [7:0] LA = 8'h40;  // loada
  localparam logic [7:0] LB = 8'h20;  // loadb
  localparam logic [7:0] AS = 8'h10;  // asel
  localparam logic [7:0] BS = 8'h08;  // bsel
  localparam logic [7:0] LC = 8'h04;  // loadc
  localparam logic [7:0] LS = 8'h02;  // loads
  localparam logic [7:0] LD = 8'h01;  // load_addr

  logic       clk;
  logic       reset;
  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;

  logic       a_w, a_write, a_loada, a_loadb, a_asel, a_bsel, a_loadc, a_loads;
  logic       a_load_addr, a_err, a_halted;
  logic [2:0] a_nsel;
  logic [3:0] a_vsel;
  logic [1:0] a_mem_cmd;

  logic       b_w, b_write, b_loada, b_loadb, b_asel, b_bsel, b_loadc, b_loads;
  logic       b_load_addr, b_err, b_halted;
  logic [2:0] b_nsel;
  logic [3:0] b_vsel;
  logic [1:0] b_mem_cmd;

  logic [19:0] out_a;
  logic [19:0] out_b;

  int total;
  int bad;

  cpu_sequencer #(.MEM_LAT(3), .CNT_W(4)) dut_a (
    .clk(clk), .reset(reset), .s(s), .opcode(opcode), .op(op),
    .w(a_w), .nsel(a_nsel), .vsel(a_vsel), .write(a_write),
    .loada(a_loada), .loadb(a_loadb), .asel(a_asel), .bsel(a_bsel),
    .loadc(a_loadc), .loads(a_loads), .load_addr(a_load_addr),
    .mem_cmd(a_mem_cmd), .err(a_err), .halted(a_halted)
  );

  cpu_sequencer #(.MEM_LAT(0), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .s(s), .opcode(opcode), .op(op),
    .w(b_w), .nsel(b_nsel), .vsel(b_vsel), .write(b_write),
    .loada(b_loada), .loadb(b_loadb), .asel(b_asel), .bsel(b_bsel),
    .loadc(b_loadc), .loads(b_loads), .load_addr(b_load_addr),
    .mem_cmd(b_mem_cmd), .err(b_err), .halted(b_halted)
  );

  assign out_a = {a_w, a_nsel, a_vsel, a_write, a_loada, a_loadb, a_asel,
                  a_bsel, a_loadc, a_loads, a_load_addr, a_mem_cmd, a_err,
                  a_halted};
  assign out_b = {b_w, b_nsel, b_vsel, b_write, b_loada, b_loadb, b_asel,
                  b_bsel, b_loadc, b_loads, b_load_addr, b_mem_cmd, b_err,
                  b_halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] pk(input logic w, input logic [2:0] nsel,
                                     input logic [3:0] vsel,
                                     input logic [7:0] stb,
                                     input logic [1:0] mc, input logic err,
                                     input logic halted);
    return {w, nsel, vsel, stb, mc, err, halted};
  endfunction

  task automatic check(input string tag, input logic [19:0] obs,
                       input logic [19:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [2:0] opc, input logic [1:0] o);
    opcode = opc;
    op     = o;
    s      = 1'b1;
  endtask

  initial begin
    logic [19:0] idle;
    logic [19:0] zero;
    idle  = pk(1'b1, 3'b000, 4'b0000, 8'h00, 2'b00, 1'b0, 1'b0);
    zero  = '0;
    total = 0;
    bad   = 0;

    reset  = 1'b1;
    s      = 1'b0;
    opcode = 3'b000;
    op     = 2'b00;

    // Reset state, during and after reset.
    #3;
    check("reset_during", out_a, idle);
    step();
    step();
    check("reset_held", out_a, idle);
    reset = 1'b0;
    check("reset_released_b", out_b, idle);

    // MOVIM: 3 cycles.
    start(3'b110, 2'b10);
    step();  check("movim_decode", out_a, zero);
    s = 1'b0;
    step();  check("movim", out_a, pk(1'b0, 3'b100, 4'b0100, WR, 2'b00, 1'b0, 1'b0));
    step();  check("movim_wait", out_a, idle);

    // ADD: 6 cycles.
    start(3'b101, 2'b00);
    step();  check("add_decode", out_a, zero);
    s = 1'b0;
    step();  check("add_geta", out_a, pk(1'b0, 3'b100, 4'b0000, LA, 2'b00, 1'b0, 1'b0));
    step();  check("add_getb", out_a, pk(1'b0, 3'b001, 4'b0000, LB, 2'b00, 1'b0, 1'b0));
    step();  check("add_alu", out_a, pk(1'b0, 3'b000, 4'b0000, LC, 2'b00, 1'b0, 1'b0));
    step();  check("add_wrc", out_a, pk(1'b0, 3'b010, 4'b0001, WR, 2'b00, 1'b0, 1'b0));
    step();  check("add_wait", out_a, idle);

    // CMP: 5 cycles, status only.
    start(3'b101, 2'b01);
    step();  s = 1'b0;
    step();  check("cmp_geta", out_a, pk(1'b0, 3'b100, 4'b0000, LA, 2'b00, 1'b0, 1'b0));
    step();  check("cmp_getb", out_a, pk(1'b0, 3'b001, 4'b0000, LB, 2'b00, 1'b0, 1'b0));
    step();  check("cmp_alu", out_a, pk(1'b0, 3'b000, 4'b0000, LS, 2'b00, 1'b0, 1'b0));
    step();  check("cmp_wait", out_a, idle);

    // MVN: 5 cycles, no GETA.
    start(3'b101, 2'b11);
    step();  s = 1'b0;
    step();  check("mvn_getb", out_a, pk(1'b0, 3'b001, 4'b0000, LB, 2'b00, 1'b0, 1'b0));
    step();  check("mvn_alu", out_a, pk(1'b0, 3'b000, 4'b0000, AS | LC, 2'b00, 1'b0, 1'b0));
    step();  check("mvn_wrc", out_a, pk(1'b0, 3'b010, 4'b0001, WR, 2'b00, 1'b0, 1'b0));
    step();  check("mvn_wait", out_a, idle);

    // MOV reg with s held high: 5 cycles, then back-to-back restart.
    start(3'b110, 2'b00);
    step();  check("movr_decode", out_a, zero);
    step();  check("movr_b", out_a, pk(1'b0, 3'b001, 4'b0000, LB, 2'b00, 1'b0, 1'b0));
    step();  check("movr_c", out_a, pk(1'b0, 3'b000, 4'b0000, AS | LC, 2'b00, 1'b0, 1'b0));
    step();  check("movr_wrc", out_a, pk(1'b0, 3'b010, 4'b0001, WR, 2'b00, 1'b0, 1'b0));
    step();  check("movr_wait", out_a, idle);
    step();  check("movr_restart_decode", out_a, zero);
    s = 1'b0;
    step();
    step();
    step();
    step();  check("movr_restart_wait", out_a, idle);

    // Illegal opcodes: err only during DECODE.
    start(3'b010, 2'b00);
    step();  check("ill_010_err", out_a, pk(1'b0, 3'b000, 4'b0000, 8'h00, 2'b00, 1'b1, 1'b0));
    s = 1'b0;
    step();  check("ill_010_wait", out_a, idle);
    start(3'b110, 2'b01);
    step();  check("ill_mov01_err", out_a, pk(1'b0, 3'b000, 4'b0000, 8'h00, 2'b00, 1'b1, 1'b0));
    s = 1'b0;
    step();  check("ill_mov01_wait", out_a, idle);

    // STR: 8 cycles.
    start(3'b100, 2'b00);
    step();  s = 1'b0;
    step();  check("str_lda", out_a, pk(1'b0, 3'b100, 4'b0000, LA, 2'b00, 1'b0, 1'b0));
    step();  check("str_ldadd", out_a, pk(1'b0, 3'b000, 4'b0000, BS | LC, 2'b00, 1'b0, 1'b0));
    step();  check("str_ldaddr", out_a, pk(1'b0, 3'b000, 4'b0000, LD, 2'b00, 1'b0, 1'b0));
    step();  check("str_stb", out_a, pk(1'b0, 3'b010, 4'b0000, LB, 2'b00, 1'b0, 1'b0));
    step();  check("str_stc", out_a, pk(1'b0, 3'b000, 4'b0000, AS | LC, 2'b00, 1'b0, 1'b0));
    step();  check("str_memwr", out_a, pk(1'b0, 3'b000, 4'b0000, 8'h00, 2'b10, 1'b0, 1'b0));
    step();  check("str_wait", out_a, idle);

    // LDR: 10 cycles with MEM_LAT=3, 7 cycles with MEM_LAT=0.
    start(3'b011, 2'b00);
    step();  s = 1'b0;
    step();
    step();
    step();  check("ldr_ldaddr", out_a, pk(1'b0, 3'b000, 4'b0000, LD, 2'b00, 1'b0, 1'b0));
    step();  check("ldr_a_memrd0", out_a, pk(1'b0, 3'b000, 4'b0000, 8'h00, 2'b01, 1'b0, 1'b0));
             check("ldr_b_memrd0", out_b, pk(1'b0, 3'b000, 4'b0000, 8'h00, 2'b01, 1'b0, 1'b0));
    step();  check("ldr_a_memrd1", out_a, pk(1'b0, 3'b000, 4'b0000, 8'h00, 2'b01, 1'b0, 1'b0));
             check("ldr_b_wrm", out_b, pk(1'b0, 3'b010, 4'b1000, WR, 2'b01, 1'b0, 1'b0));
    step();  check("ldr_a_memrd2", out_a, pk(1'b0, 3'b000, 4'b0000, 8'h00, 2'b01, 1'b0, 1'b0));
             check("ldr_b_wait", out_b, idle);
    step();  check("ldr_a_memrd3", out_a, pk(1'b0, 3'b000, 4'b0000, 8'h00, 2'b01, 1'b0, 1'b0));
    step();  check("ldr_a_wrm", out_a, pk(1'b0, 3'b010, 4'b1000, WR, 2'b01, 1'b0, 1'b0));
    step();  check("ldr_a_wait", out_a, idle);
             check("ldr_b_still_wait", out_b, idle);

    // Reset in the middle of MEMRD acts immediately.
    start(3'b011, 2'b00);
    step();  s = 1'b0;
    step();
    step();
    step();
    step();  check("rst_pre_memrd", out_a, pk(1'b0, 3'b000, 4'b0000, 8'h00, 2'b01, 1'b0, 1'b0));
    #2 reset = 1'b1;
    #1 check("rst_mid_memrd_a", out_a, idle);
       check("rst_mid_memrd_b", out_b, idle);
    step();
    reset = 1'b0;
    start(3'b110, 2'b10);
    step();  check("rst_restart_decode", out_a, zero);
    s = 1'b0;
    step();  check("rst_restart_movim", out_a, pk(1'b0, 3'b100, 4'b0100, WR, 2'b00, 1'b0, 1'b0));
    step();  check("rst_restart_wait", out_a, idle);

    // HALT: sticky for 20 cycles with s toggling, only reset exits.
    start(3'b111, 2'b00);
    step();  check("halt_decode", out_a, zero);
    for (int i = 0; i < 20; i++) begin
      s = i[0];
      step();
      check($sformatf("halt_cyc%0d", i), out_a,
            pk(1'b0, 3'b000, 4'b0000, 8'h00, 2'b00, 1'b0, 1'b1));
    end
    s = 1'b0;
    #2 reset = 1'b1;
    #1 check("halt_reset", out_a, idle);
    step();
    reset = 1'b0;
    step();  check("halt_after_reset", out_a, idle);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
